// File: rtl/fetch_stage.sv
// fetch_stage: PC, valid/ready imem fetch, IF/ID register with one-entry skid, branch redirect with in-flight drain
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext
);
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;
  state_t state, state_nx;
  logic [31:0] pc, drain_addr, skid_instr, skid_pc;
  logic skid_valid, xfer, free;
  always_comb begin
    imem_req  = (state == FETCH && !skid_valid) || state == DRAIN;
    imem_addr = state == DRAIN ? drain_addr : pc;
    xfer      = imem_req && imem_ready;
    free      = !if_valid || !stall;
    state_nx  = state == BOOT  ? FETCH :
                state == DRAIN ? (imem_ready ? FETCH : DRAIN) :
                (branch_taken && imem_req && !imem_ready) ? DRAIN : FETCH;
  end
  always_ff @(posedge clk)
    state <= reset ? BOOT : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= PC_RESET;
      drain_addr <= PC_RESET;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= PC_RESET;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= PC_RESET;
    end else if (branch_taken) begin
      pc         <= branch_target & 32'hFFFF_FFFC;
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
      if (state != DRAIN) drain_addr <= pc;
    end else if (state == FETCH && xfer) begin
      pc <= pc + 32'd4;
      if (free) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_valid <= 1'b1;
      end else begin
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
        skid_valid <= 1'b1;
      end
    end else if (!stall) begin
      if (skid_valid) begin
        if_instr   <= skid_instr;
        if_pc      <= skid_pc;
        skid_valid <= 1'b0;
      end else begin
        if_valid <= 1'b0;
      end
    end
  end
  assign if_pc_plus4 = if_pc + 32'd4;
  assign opcode      = if_instr[31:26];
  assign rs          = if_instr[25:21];
  assign rt          = if_instr[20:16];
  assign rd          = if_instr[15:11];
  assign shamt       = if_instr[10:6];
  assign funct       = if_instr[5:0];
  assign imm_sext    = {{16{if_instr[15]}}, if_instr[15:0]};
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register feeding the control unit and register file. Holds the PC and fetches one 32-bit instruction per accepted request over a valid/ready memory port. It presents the latched instruction and its pre-split fields (opcode, funct, rs, rt, rd, shamt, immediate) to decode, and absorbs decode stalls through a one-entry skid buffer. It also handles branch redirects, including draining a request that is still in flight.

## Interface
- PC_RESET, 32'h0000_0000, PC value after reset; must be word-aligned
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- stall  in  1  decode cannot accept; IF/ID holds its contents
- branch_taken  in  1  single-cycle redirect request
- branch_target  in  32  redirect address; bits [1:0] ignored and forced to 00
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (word-aligned)
- imem_ready  in  1  memory accepts request; imem_rdata valid in the same cycle
- imem_rdata  in  32  instruction word
- if_valid  out  1  IF/ID holds a live instruction
- if_instr  out  32  latched instruction
- if_pc, if_pc_plus4  out  32 each  address of if_instr, and that address + 4
- opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0]  out  slices of if_instr
- imm_sext  out  32  if_instr[15:0] sign-extended

## Operation
- State machine with states BOOT, FETCH and DRAIN.
  - Reset enters BOOT.
  - BOOT→FETCH unconditionally after one cycle; imem_req=0 in BOOT.
- Handshake: a transfer completes in any cycle where imem_req && imem_ready.
  - Once imem_req rises, it and imem_addr stay stable until that transfer completes.
  - At most one request is outstanding.
- FETCH raising imem_req:
  - imem_req may newly rise only when the skid buffer is empty.
  - imem_addr = pc.
- On a completed transfer in FETCH: pc <= pc + 4, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
- Response routing, where IF/ID is "free" = !if_valid || !stall:
  - IF/ID free: if_instr <= imem_rdata, if_pc <= imem_addr, if_valid <= 1.
  - IF/ID not free: word and address go to the skid buffer, skid_valid <= 1.
- Skid drain: when stall=0 and skid_valid, IF/ID <= skid contents, skid_valid <= 0. A new request cannot rise while the skid is full, so no collision with a completing transfer is possible.
- stall=0 with IF/ID full and nothing arriving: if_valid <= 0, i.e. the instruction was consumed.
- Redirect (branch_taken=1), evaluated before any stall handling:
  - pc <= {branch_target[31:2],2'b00}, if_valid <= 0, skid_valid <= 0.
  - Request outstanding and not completing this cycle: go to DRAIN. DRAIN keeps imem_req/imem_addr at the old values until ready, discards the data, then returns to FETCH.
  - Request completing in the redirect cycle: its data is discarded; stay in FETCH.
  - branch_taken during DRAIN: update pc to the new target and remain in DRAIN.
- Priority: reset > branch_taken > stall > normal fetch.
- While if_valid=0, decode is required to ignore the field outputs. Those outputs are not forced to zero except at reset.

## Timing
- Reset values:
  - imem_req=0, imem_addr=PC_RESET.
  - if_valid=0, if_instr=0, all field outputs 0.
  - if_pc=PC_RESET, if_pc_plus4=PC_RESET+4.
  - Skid empty, pc=PC_RESET, state BOOT.
- Reset asserted mid-transfer drops imem_req on the next edge; the memory must tolerate an abandoned request.
- First imem_req is high in the 2nd cycle after reset deasserts.
- Latency: transfer in cycle N with IF/ID free → if_valid and if_instr visible in N+1.
- Throughput: 1 instruction/cycle with imem_ready tied high and stall=0. imem_req can stay high across back-to-back transfers.
- Redirect in cycle N with no outstanding request: imem_addr equals the target in N+1.
- Field outputs and if_pc_plus4 are combinational from the IF/ID register, with no extra latency.

## Test plan
- **Reset and boot:** reset 3 cycles, imem_ready=1, memory returns addr-derived words.
  - imem_req rises in the 2nd post-reset cycle at 0x0.
  - if_pc sequence 0x0, 0x4, 0x8 on consecutive cycles, if_valid=1 from the 3rd cycle.
- **Field split:** fetch 32'h2128_FFFC (addi $8,$9,-4).
  - Required: opcode=6'b001000, rs=9, rt=8, imm_sext=32'hFFFF_FFFC.
- **Stall with skid:** stall=1 for 3 cycles while a transfer completes.
  - IF/ID holds; the skid captures the next word.
  - imem_req stays 0 until release.
  - On release, the skid word appears the next cycle with no lost or duplicated PC.
- **Redirect during wait:** imem_ready=0 for 4 cycles on addr 0x10; pulse branch_taken with target 0x40 in wait cycle 2.
  - imem_addr stays 0x10 until ready; that data is discarded.
  - Next request is to 0x40; if_valid=0 throughout.
- **Redirect with stall:** branch_taken=1 with stall=1 and if_valid=1.
  - if_valid=0 next cycle; fetching resumes at the target.
- **PC wrap:** PC_RESET=32'hFFFF_FFF8, imem_ready=1.
  - Addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
